mem_arbiter: RTL and testbench

Shares the single-port development memory system (RAM 0x0000-0x0FFF, ROM 0xF000-0xFFFF) between the CPU and one DMA/loader requester. The block performs one memory access per clock. Reads return one cycle later, matching the memory's registered read. The CPU has priority, and a starvation counter guarantees the DMA a bounded-latency burst.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the single-port development memory: one access per clock,
// CPU priority, and a starvation counter that forces the DMA in for a bounded burst.
//
// state     | meaning
// CPU_OWN   | CPU has priority; DMA is served when the CPU is idle or when starved
// DMA_BURST | DMA was forced in and keeps the bus for the rest of its burst
module mem_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4,
  parameter int BURST    = 4
) (
  input  logic        i_ph2,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_rdy,
  output logic        o_cpu_rvalid,
  output logic [7:0]  o_cpu_rdata,
  input  logic        i_dma_req,
  input  logic [15:0] i_dma_addr,
  input  logic        i_dma_rw,
  input  logic [7:0]  i_dma_wdata,
  output logic        o_dma_gnt,
  output logic        o_dma_rvalid,
  output logic [7:0]  o_dma_rdata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rw,
  inout  wire  [7:0]  io_mem_data
);

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_LOAD  = BEAT_W'(BURST - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);

  typedef enum logic {CPU_OWN, DMA_BURST} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_nxt;
  owner_t            r_rd_owner, w_rd_owner_nxt;
  logic [7:0]        r_cpu_rdata, r_dma_rdata;
  logic              w_cpu_gnt, w_dma_gnt;
  logic [7:0]        w_wdata;

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    if (!i_reset) begin
      case (r_state)
        CPU_OWN: begin
          if (i_dma_req && (r_wait_cnt == MAX_WAIT_C)) begin
            w_dma_gnt = 1'b1;
            // The forced beat is the first of the burst; a one-beat burst needs no burst state.
            if (BURST > 1) begin
              w_state_nxt = DMA_BURST;
              w_beat_nxt  = BEAT_LOAD;
            end
          end else if (i_cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else if (i_dma_req) begin
            w_dma_gnt = 1'b1;
          end
        end
        DMA_BURST: begin
          if (i_dma_req) begin
            w_dma_gnt = 1'b1;
            if (r_beat_cnt <= BEAT_ONE) begin
              w_state_nxt = CPU_OWN;
              w_beat_nxt  = '0;
            end else begin
              w_beat_nxt = r_beat_cnt - BEAT_ONE;
            end
          end else begin
            w_cpu_gnt   = i_cpu_req;
            w_state_nxt = CPU_OWN;
            w_beat_nxt  = '0;
          end
        end
        default: w_state_nxt = CPU_OWN;
      endcase
    end
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!i_dma_req || w_dma_gnt) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != MAX_WAIT_C) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    w_rd_owner_nxt = OWN_NONE;
    if (w_cpu_gnt && i_cpu_rw) begin
      w_rd_owner_nxt = OWN_CPU;
    end else if (w_dma_gnt && i_dma_rw) begin
      w_rd_owner_nxt = OWN_DMA;
    end
  end

  always_comb begin
    o_mem_addr = 16'h0000;
    o_mem_rw   = 1'b1;
    w_wdata    = 8'h00;
    if (w_cpu_gnt) begin
      o_mem_addr = i_cpu_addr;
      o_mem_rw   = i_cpu_rw;
      w_wdata    = i_cpu_wdata;
    end else if (w_dma_gnt) begin
      o_mem_addr = i_dma_addr;
      o_mem_rw   = i_dma_rw;
      w_wdata    = i_dma_wdata;
    end
  end

  assign io_mem_data = (!o_mem_rw && !i_reset) ? w_wdata : 8'hzz;

  assign o_cpu_rdy    = w_cpu_gnt;
  assign o_dma_gnt    = w_dma_gnt;
  assign o_cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign o_dma_rvalid = (r_rd_owner == OWN_DMA);
  // Memory data is only on the bus during the return cycle, so pass it through and keep a copy.
  assign o_cpu_rdata  = o_cpu_rvalid ? io_mem_data : r_cpu_rdata;
  assign o_dma_rdata  = o_dma_rvalid ? io_mem_data : r_dma_rdata;

  always_ff @(posedge i_ph2 or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= CPU_OWN;
      r_wait_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_rd_owner  <= OWN_NONE;
      r_cpu_rdata <= 8'h00;
      r_dma_rdata <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_rd_owner <= w_rd_owner_nxt;
      if (o_cpu_rvalid) r_cpu_rdata <= io_mem_data;
      if (o_dma_rvalid) r_dma_rdata <= io_mem_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// counting reference model; a registered-read memory sits on the shared bus.
module tb_mem_arbiter;

  localparam int MW = 4;
  localparam int BU = 2;

  logic        ph2 = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw, dma_req, dma_rw;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_rdy, cpu_rvalid, dma_gnt, dma_rvalid, mem_rw;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MAX_WAIT(MW), .WAIT_W(4), .BURST(BU)) dut (
    .i_ph2(ph2), .i_reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_rw(cpu_rw), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdy(cpu_rdy), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dma_req(dma_req), .i_dma_addr(dma_addr), .i_dma_rw(dma_rw), .i_dma_wdata(dma_wdata),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_mem_addr(mem_addr), .o_mem_rw(mem_rw), .io_mem_data(mem_data)
  );

  always #5 ph2 = ~ph2;

  function automatic logic [7:0] init_val(int i);
    if (i == 32'hF000) return 8'hA9;
    if (i > 32'hF000) return 8'(i) ^ 8'h3C;
    return 8'(i * 7);
  endfunction

  // Memory: registered read, drives the bus only in the cycle after a read access.
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] rd_q;
  logic       rd_drv;

  always @(posedge ph2 or posedge reset) begin
    if (reset) begin
      rd_drv <= 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
    end else begin
      rd_drv <= (cpu_rdy || dma_gnt) && mem_rw;
      rd_q   <= mem[mem_addr];
      if ((cpu_rdy || dma_gnt) && !mem_rw && mem_addr < 16'hF000) mem[mem_addr] <= mem_data;
    end
  end

  assign mem_data = (rd_drv && mem_rw && !reset) ? rd_q : 8'hzz;

  task automatic idle_inputs();
    cpu_req = 0; cpu_rw = 1; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_rw = 1; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; cpu_req = 1; dma_req = 1; cpu_rw = 0; dma_rw = 0;
    cpu_addr = 16'h0123; dma_addr = 16'h0456;
    repeat (2) @(posedge ph2);
    @(negedge ph2);
    total++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL reset_cpu_rdy got %b want 0", cpu_rdy); end
    total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL reset_dma_gnt got %b want 0", dma_gnt); end
    total++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got %b want 00", {cpu_rvalid, dma_rvalid}); end
    total++; if ({cpu_rdata, dma_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got %h want 0000", {cpu_rdata, dma_rdata}); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
    total++; if (mem_rw !== 1'b1) begin bad++; $display("FAIL reset_mem_rw got %b want 1", mem_rw); end
    idle_inputs();
    @(posedge ph2); #1 reset = 0;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'hF000;
    @(negedge ph2);
    total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL rd_cpu_rdy got %b want 1", cpu_rdy); end
    total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rd_dma_gnt got %b want 0", dma_gnt); end
    total++; if (mem_addr !== 16'hF000 || mem_rw !== 1'b1) begin bad++; $display("FAIL rd_mem_bus got %h/%b want f000/1", mem_addr, mem_rw); end
    @(posedge ph2); #1 idle_inputs();
    @(negedge ph2);
    total++; if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid got %b want 1", cpu_rvalid); end
    total++; if (cpu_rdata !== 8'hA9) begin bad++; $display("FAIL rd_rdata got %h want a9", cpu_rdata); end
    total++; if (dma_gnt !== 1'b0 || dma_rvalid !== 1'b0) begin bad++; $display("FAIL rd_dma_quiet got %b%b want 00", dma_gnt, dma_rvalid); end
    @(posedge ph2); #1;
  endtask

  task automatic test_write_readback();
    cpu_req = 1; cpu_rw = 0; cpu_addr = 16'h0010; cpu_wdata = 8'h5C;
    @(negedge ph2);
    total++; if (cpu_rdy !== 1'b1 || mem_rw !== 1'b0) begin bad++; $display("FAIL wr_grant got rdy=%b rw=%b want 1/0", cpu_rdy, mem_rw); end
    total++; if (mem_data !== 8'h5C) begin bad++; $display("FAIL wr_bus got %h want 5c", mem_data); end
    @(posedge ph2); #1 cpu_rw = 1;
    @(negedge ph2);
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got %b want 0", cpu_rvalid); end
    total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL wr_rb_rdy got %b want 1", cpu_rdy); end
    @(posedge ph2); #1 idle_inputs();
    @(negedge ph2);
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5C) begin bad++; $display("FAIL wr_readback got %b/%h want 1/5c", cpu_rvalid, cpu_rdata); end
    @(posedge ph2); #1;
  endtask

  task automatic test_starvation();
    logic exp;
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0100;
    dma_req = 1; dma_rw = 1; dma_addr = 16'h0200;
    for (int k = 0; k < 12; k++) begin
      exp = ((k % 6) >= MW);
      @(negedge ph2);
      total++; if (dma_gnt !== exp) begin bad++; $display("FAIL starve_dma_gnt[%0d] got %b want %b", k, dma_gnt, exp); end
      total++; if (cpu_rdy !== !exp) begin bad++; $display("FAIL starve_cpu_rdy[%0d] got %b want %b", k, cpu_rdy, !exp); end
      @(posedge ph2); #1;
    end
    idle_inputs();
    @(posedge ph2); #1;
  endtask

  task automatic test_dma_idle();
    for (int i = 0; i < 4; i++) begin
      dma_req = 1; dma_rw = 0; dma_addr = 16'h0020 + 16'(i); dma_wdata = 8'h90 + 8'(i);
      @(negedge ph2);
      total++; if (dma_gnt !== 1'b1 || cpu_rdy !== 1'b0) begin bad++; $display("FAIL idle_gnt[%0d] got gnt=%b rdy=%b want 1/0", i, dma_gnt, cpu_rdy); end
      total++; if (mem_data !== 8'h90 + 8'(i)) begin bad++; $display("FAIL idle_bus[%0d] got %h want %h", i, mem_data, 8'h90 + 8'(i)); end
      @(posedge ph2); #1;
    end
    // Still in CPU_OWN with no starvation: the CPU must win a contested cycle.
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0030; dma_rw = 1;
    @(negedge ph2);
    total++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin bad++; $display("FAIL idle_state got rdy=%b gnt=%b want 1/0", cpu_rdy, dma_gnt); end
    @(posedge ph2); #1 idle_inputs();
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[16'h0020 + i] !== 8'h90 + 8'(i)) begin bad++; $display("FAIL idle_mem[%0d] got %h want %h", i, mem[16'h0020 + i], 8'h90 + 8'(i)); end
    end
    @(posedge ph2); #1;
  endtask

  task automatic test_early_exit();
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0040;
    dma_req = 1; dma_rw = 1; dma_addr = 16'h0050;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) dma_req = 0;
      if (k == 6) dma_req = 1;
      @(negedge ph2);
      if (k == 4) begin
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL exit_forced got %b want 1", dma_gnt); end
      end else begin
        total++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin bad++; $display("FAIL exit_cpu[%0d] got rdy=%b gnt=%b want 1/0", k, cpu_rdy, dma_gnt); end
      end
      @(posedge ph2); #1;
    end
    idle_inputs();
    @(posedge ph2); #1;
  endtask

  task automatic test_reset_mid_read();
    dma_req = 1; dma_rw = 1; dma_addr = 16'hF000;
    @(negedge ph2);
    total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got %b want 1", dma_gnt); end
    @(posedge ph2); #1 idle_inputs();
    total++; if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hA9) begin bad++; $display("FAIL mid_pre got %b/%h want 1/a9", dma_rvalid, dma_rdata); end
    reset = 1;
    #1;
    total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid got %b want 0", dma_rvalid); end
    total++; if (dma_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin bad++; $display("FAIL mid_rdata got %h/%h want 00/00", dma_rdata, cpu_rdata); end
    total++; if (mem_addr !== 16'h0000 || mem_rw !== 1'b1) begin bad++; $display("FAIL mid_bus got %h/%b want 0000/1", mem_addr, mem_rw); end
    @(posedge ph2); #1 reset = 0;
    @(negedge ph2);
    total++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin bad++; $display("FAIL mid_after got %b%b want 00", cpu_rvalid, dma_rvalid); end
    @(posedge ph2); #1;
  endtask

  // Reference: count denied DMA cycles and remaining burst beats, track reads by address.
  task automatic test_random();
    int denied = 0, burst_left = 0, e = 0;
    bit forced, cpu_pend = 0, prev_read = 0;
    logic [15:0] p_addr = 0, e_addr;
    logic p_rw = 1, e_rw;
    logic [7:0] p_data = 0;
    bit cpu_rv = 0, dma_rv = 0;
    logic [7:0] cpu_rd = 0, dma_rd = 0, cpu_hold = 0, dma_hold = 0;
    reset = 1; idle_inputs();
    @(posedge ph2); #1 reset = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    for (int n = 0; n < 400; n++) begin
      if (!cpu_pend && $urandom_range(0, 2) != 0) begin
        cpu_pend = 1;
        p_data = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin p_addr = 16'hF000 | 16'($urandom_range(0, 255)); p_rw = 1; end
        else begin p_addr = 16'($urandom_range(0, 63)); p_rw = 1'($urandom_range(0, 1)); end
      end
      cpu_req = cpu_pend && !(prev_read && !p_rw);
      cpu_addr = p_addr; cpu_rw = p_rw; cpu_wdata = p_data;
      dma_req = ($urandom_range(0, 4) != 0);
      dma_addr = 16'($urandom_range(0, 63));
      dma_rw = prev_read ? 1'b1 : 1'($urandom_range(0, 1));
      dma_wdata = 8'($urandom);

      forced = 0;
      if (burst_left > 0) e = dma_req ? 2 : (cpu_req ? 1 : 0);
      else if (dma_req && denied >= MW) begin e = 2; forced = 1; end
      else e = cpu_req ? 1 : (dma_req ? 2 : 0);
      e_addr = (e == 1) ? cpu_addr : (e == 2) ? dma_addr : 16'h0000;
      e_rw   = (e == 1) ? cpu_rw : (e == 2) ? dma_rw : 1'b1;

      @(negedge ph2);
      total++; if (cpu_rdy !== (e == 1) || dma_gnt !== (e == 2)) begin bad++; $display("FAIL rnd_grant[%0d] got rdy=%b gnt=%b want %b/%b", n, cpu_rdy, dma_gnt, e == 1, e == 2); end
      total++; if (mem_addr !== e_addr || mem_rw !== e_rw) begin bad++; $display("FAIL rnd_bus[%0d] got %h/%b want %h/%b", n, mem_addr, mem_rw, e_addr, e_rw); end
      if (!e_rw) begin
        total++; if (mem_data !== ((e == 1) ? cpu_wdata : dma_wdata)) begin bad++; $display("FAIL rnd_wdata[%0d] got %h want %h", n, mem_data, (e == 1) ? cpu_wdata : dma_wdata); end
      end
      total++; if (cpu_rvalid !== cpu_rv || dma_rvalid !== dma_rv) begin bad++; $display("FAIL rnd_rvalid[%0d] got %b%b want %b%b", n, cpu_rvalid, dma_rvalid, cpu_rv, dma_rv); end
      total++; if (cpu_rdata !== (cpu_rv ? cpu_rd : cpu_hold)) begin bad++; $display("FAIL rnd_cpu_rdata[%0d] got %h want %h", n, cpu_rdata, cpu_rv ? cpu_rd : cpu_hold); end
      total++; if (dma_rdata !== (dma_rv ? dma_rd : dma_hold)) begin bad++; $display("FAIL rnd_dma_rdata[%0d] got %h want %h", n, dma_rdata, dma_rv ? dma_rd : dma_hold); end
      @(posedge ph2); #1;

      if (cpu_rv) cpu_hold = cpu_rd;
      if (dma_rv) dma_hold = dma_rd;
      cpu_rv = (e == 1) && cpu_rw;
      dma_rv = (e == 2) && dma_rw;
      if (e != 0) begin
        if (e_rw) begin
          if (e == 1) cpu_rd = ref_mem[e_addr]; else dma_rd = ref_mem[e_addr];
        end else if (e_addr < 16'hF000) begin
          ref_mem[e_addr] = (e == 1) ? cpu_wdata : dma_wdata;
        end
      end
      prev_read = (e != 0) && e_rw;
      if (e == 1) cpu_pend = 0;
      if (!dma_req) begin denied = 0; burst_left = 0; end
      else if (e == 2) begin
        denied = 0;
        if (forced) burst_left = BU - 1;
        else if (burst_left > 0) burst_left--;
      end else if (denied < MW) denied++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_write_readback();
    test_starvation();
    test_dma_idle();
    test_early_exit();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
